// File: rtl/wr_channel_router.sv
// Write-channel router: captures one AW from the address decoder, steers AW/W/B to the
// selected slave and generates WLAST from a beat counter. Optional B watchdog: WR_ROUTER_TIMEOUT_EN.
module wr_channel_router #(
    parameter int LEN_W          = 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_slave1_sel,
    input  logic             wr_slave2_sel,
    input  logic [31:0]      s1_wr_addr,
    input  logic [31:0]      s2_wr_addr,
    input  logic [LEN_W-1:0] m_awlen,
    input  logic             m_awvalid,
    output logic             m_awready,
    input  logic [31:0]      m_wdata,
    input  logic [3:0]       m_wstrb,
    input  logic             m_wlast,
    input  logic             m_wvalid,
    output logic             m_wready,
    output logic [1:0]       m_bresp,
    output logic             m_bvalid,
    input  logic             m_bready,
    output logic [LEN_W-1:0] s_awlen,
    output logic [31:0]      s_wdata,
    output logic [3:0]       s_wstrb,
    output logic             s_wlast,
    output logic [31:0]      s1_awaddr,
    output logic [31:0]      s2_awaddr,
    output logic             s1_awvalid,
    input  logic             s1_awready,
    output logic             s2_awvalid,
    input  logic             s2_awready,
    output logic             s1_wvalid,
    input  logic             s1_wready,
    output logic             s2_wvalid,
    input  logic             s2_wready,
    input  logic [1:0]       s1_bresp,
    input  logic             s1_bvalid,
    output logic             s1_bready,
    input  logic [1:0]       s2_bresp,
    input  logic             s2_bvalid,
    output logic             s2_bready,
    output logic             wlast_err
);

    // state | meaning
    // IDLE  | accepting a new AW from the master
    // ADDR  | presenting the latched AW to the selected slave
    // DATA  | steering W beats, counting toward the generated WLAST
    // RESP  | steering the B response back to the master
    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t           state_q, state_d;
    logic             sel2_q;
    logic [31:0]      s1_addr_q, s2_addr_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W:0]   beat_cnt_q;
    logic             capture, beat_inc, last_beat, w_hs;
    logic             sel_awready, sel_wready, sel_bvalid, timed_out;
    logic [1:0]       sel_bresp;

    assign sel_awready = sel2_q ? s2_awready : s1_awready;
    assign sel_wready  = sel2_q ? s2_wready  : s1_wready;
    assign sel_bvalid  = sel2_q ? s2_bvalid  : s1_bvalid;
    assign sel_bresp   = sel2_q ? s2_bresp   : s1_bresp;
    // Extra counter bit lets a 256-beat burst reach its last beat without wrapping.
    assign last_beat   = (beat_cnt_q == {1'b0, len_q});
    assign w_hs        = m_wvalid & sel_wready;
    assign s1_awaddr   = s1_addr_q;
    assign s2_awaddr   = s2_addr_q;
    assign s_awlen     = len_q;

`ifdef WR_ROUTER_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

    assign timed_out = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES));

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (state_q != RESP) tmo_cnt_d = '0;
        else if (!timed_out && !sel_bvalid) tmo_cnt_d = tmo_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) tmo_cnt_q <= '0;
        else     tmo_cnt_q <= tmo_cnt_d;
    end
`else
    // Watchdog not built: RESP waits on the slave indefinitely.
    assign timed_out = (TIMEOUT_CYCLES < 0);
`endif

    always_comb begin
        state_d    = state_q;
        capture    = 1'b0;
        beat_inc   = 1'b0;
        m_awready  = 1'b0;
        m_wready   = 1'b0;
        m_bvalid   = 1'b0;
        m_bresp    = 2'b00;
        s_wdata    = '0;
        s_wstrb    = '0;
        s_wlast    = 1'b0;
        s1_awvalid = 1'b0;
        s2_awvalid = 1'b0;
        s1_wvalid  = 1'b0;
        s2_wvalid  = 1'b0;
        s1_bready  = 1'b0;
        s2_bready  = 1'b0;
        wlast_err  = 1'b0;
        if (!rst) begin
            case (state_q)
                IDLE: begin
                    m_awready = 1'b1;
                    if (m_awvalid && (wr_slave1_sel || wr_slave2_sel)) begin
                        capture = 1'b1;
                        state_d = ADDR;
                    end
                end
                ADDR: begin
                    s1_awvalid = ~sel2_q;
                    s2_awvalid = sel2_q;
                    if (sel_awready) state_d = DATA;
                end
                DATA: begin
                    s_wdata   = m_wdata;
                    s_wstrb   = m_wstrb;
                    s_wlast   = last_beat;
                    s1_wvalid = m_wvalid & ~sel2_q;
                    s2_wvalid = m_wvalid & sel2_q;
                    m_wready  = sel_wready;
                    if (w_hs) begin
                        beat_inc  = 1'b1;
                        wlast_err = (m_wlast != last_beat);
                        if (last_beat) state_d = RESP;
                    end
                end
                RESP: begin
                    if (timed_out) begin
                        m_bvalid = 1'b1;
                        m_bresp  = 2'b10;
                        if (m_bready) state_d = IDLE;
                    end else begin
                        m_bvalid  = sel_bvalid;
                        m_bresp   = sel_bresp;
                        s1_bready = m_bready & ~sel2_q;
                        s2_bready = m_bready & sel2_q;
                        if (sel_bvalid && m_bready) state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            sel2_q     <= 1'b0;
            s1_addr_q  <= '0;
            s2_addr_q  <= '0;
            len_q      <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (capture) begin
                // Slave 1 wins if the decoder ever asserts both selects.
                sel2_q     <= ~wr_slave1_sel;
                s1_addr_q  <= wr_slave1_sel ? s1_wr_addr : '0;
                s2_addr_q  <= wr_slave1_sel ? '0 : s2_wr_addr;
                len_q      <= m_awlen;
                beat_cnt_q <= '0;
            end else if (beat_inc) begin
                beat_cnt_q <= beat_cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wr_channel_router.sv
// Self-checking bench for wr_channel_router: directed test-plan steps, then random
// transactions checked cycle by cycle against a transaction-level model.
module tb_wr_channel_router;
    localparam int LEN_W = 8;
    localparam int TMO   = 16;
`ifdef WR_ROUTER_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic wr_slave1_sel = 0, wr_slave2_sel = 0;
    logic [31:0] s1_wr_addr = '0, s2_wr_addr = '0;
    logic [LEN_W-1:0] m_awlen = '0;
    logic m_awvalid = 0, m_awready;
    logic [31:0] m_wdata = '0;
    logic [3:0] m_wstrb = '0;
    logic m_wlast = 0, m_wvalid = 0, m_wready;
    logic [1:0] m_bresp;
    logic m_bvalid, m_bready = 0;
    logic [LEN_W-1:0] s_awlen;
    logic [31:0] s_wdata;
    logic [3:0] s_wstrb;
    logic s_wlast;
    logic [31:0] s1_awaddr, s2_awaddr;
    logic s1_awvalid, s1_awready = 0, s2_awvalid, s2_awready = 0;
    logic s1_wvalid, s1_wready = 0, s2_wvalid, s2_wready = 0;
    logic [1:0] s1_bresp = '0, s2_bresp = '0;
    logic s1_bvalid = 0, s1_bready, s2_bvalid = 0, s2_bready;
    logic wlast_err;

    int total = 0;
    int bad = 0;

    wr_channel_router #(.LEN_W(LEN_W), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .wr_slave1_sel(wr_slave1_sel), .wr_slave2_sel(wr_slave2_sel),
        .s1_wr_addr(s1_wr_addr), .s2_wr_addr(s2_wr_addr),
        .m_awlen(m_awlen), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast),
        .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .s_awlen(s_awlen), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wlast(s_wlast),
        .s1_awaddr(s1_awaddr), .s2_awaddr(s2_awaddr),
        .s1_awvalid(s1_awvalid), .s1_awready(s1_awready),
        .s2_awvalid(s2_awvalid), .s2_awready(s2_awready),
        .s1_wvalid(s1_wvalid), .s1_wready(s1_wready),
        .s2_wvalid(s2_wvalid), .s2_wready(s2_wready),
        .s1_bresp(s1_bresp), .s1_bvalid(s1_bvalid), .s1_bready(s1_bready),
        .s2_bresp(s2_bresp), .s2_bvalid(s2_bvalid), .s2_bready(s2_bready),
        .wlast_err(wlast_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fail_bound(input string tag);
        total++;
        bad++;
        $error("FAIL %s observed=no-handshake expected=handshake-within-budget", tag);
    endtask

    // Selected slave gets the given values; the other slave gets noise the router must ignore.
    task automatic set_slave(input bit to1, input logic awr, input logic wr,
                             input logic bv, input logic [1:0] br);
        if (to1) begin
            s1_awready = awr; s1_wready = wr; s1_bvalid = bv; s1_bresp = br;
            s2_awready = 1'($urandom); s2_wready = 1'($urandom);
            s2_bvalid = 1'($urandom); s2_bresp = 2'($urandom);
        end else begin
            s2_awready = awr; s2_wready = wr; s2_bvalid = bv; s2_bresp = br;
            s1_awready = 1'($urandom); s1_wready = 1'($urandom);
            s1_bvalid = 1'($urandom); s1_bresp = 2'($urandom);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        m_awvalid = 1; wr_slave1_sel = 1; wr_slave2_sel = 1; m_wvalid = 1; m_bready = 1;
        s1_awready = 1; s1_wready = 1; s1_bvalid = 1; s2_awready = 1; s2_wready = 1; s2_bvalid = 1;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); #1;
            chk("rst_outputs_zero", 64'(|{m_awready, m_wready, m_bresp, m_bvalid, s_awlen, s_wdata,
                s_wstrb, s_wlast, s1_awaddr, s2_awaddr, s1_awvalid, s2_awvalid, s1_wvalid,
                s2_wvalid, s1_bready, s2_bready, wlast_err}), 64'(0));
        end
        rst = 1'b0;
        m_awvalid = 0; wr_slave1_sel = 0; wr_slave2_sel = 0;
        s1_bvalid = 0; s2_bvalid = 0;
        @(negedge clk); #1;
        chk("post_rst_awready", 64'(m_awready), 64'(1));
        chk("post_rst_wready", 64'(m_wready), 64'(0));
        chk("post_rst_wvalid", 64'(s1_wvalid | s2_wvalid), 64'(0));
        m_wvalid = 0;
    endtask

    // One transaction; abort_at >= 0 resets the DUT after that many accepted beats.
    task automatic run_txn(input bit sel1, input bit sel2, input logic [31:0] a1,
                           input logic [31:0] a2, input int len, input logic [255:0] flip,
                           input int stall_pct, input int first_stall, input int aw_dly,
                           input int b_dly, input logic [1:0] bresp, input int abort_at);
        bit to1, hs, bv, to, ebv, wr_v, exp_last, done;
        int i, cyc;
        logic [31:0] exp_addr;
        to1 = sel1;
        exp_addr = sel1 ? a1 : a2;

        @(negedge clk);
        m_awvalid = 1; wr_slave1_sel = sel1; wr_slave2_sel = sel2;
        s1_wr_addr = a1; s2_wr_addr = a2; m_awlen = LEN_W'(len); m_wvalid = 1; m_bready = 1;
        set_slave(to1, 1'b0, 1'b0, 1'b0, 2'b00);
        #1;
        chk("aw_ready_idle", 64'(m_awready), 64'(1));
        chk("idle_wready", 64'(m_wready), 64'(0));

        for (int d = 0; d <= aw_dly; d++) begin
            @(negedge clk);
            m_awvalid = 0; wr_slave1_sel = 0; wr_slave2_sel = 0;
            s1_wr_addr = $urandom; s2_wr_addr = $urandom; m_awlen = LEN_W'($urandom);
            m_wvalid = 1;
            set_slave(to1, 1'(d == aw_dly), 1'b1, 1'b0, 2'b00);
            #1;
            chk("aw_valid_sel", 64'(to1 ? s1_awvalid : s2_awvalid), 64'(1));
            chk("aw_valid_other", 64'(to1 ? s2_awvalid : s1_awvalid), 64'(0));
            chk("aw_addr", 64'(to1 ? s1_awaddr : s2_awaddr), 64'(exp_addr));
            chk("aw_len", 64'(s_awlen), 64'(len));
            chk("addr_wready", 64'(m_wready), 64'(0));
            chk("addr_wvalid", 64'(s1_wvalid | s2_wvalid), 64'(0));
            chk("addr_awready", 64'(m_awready), 64'(0));
        end

        i = 0;
        cyc = 0;
        while (i <= len) begin
            if (cyc > 16 * (len + 1) + 64) begin
                fail_bound("data_bound");
                return;
            end
            @(negedge clk);
            m_wvalid = (cyc < first_stall) ? 1'b1 : 1'($urandom_range(99) >= stall_pct);
            wr_v     = (cyc < first_stall) ? 1'b0 : 1'($urandom_range(99) >= stall_pct);
            m_wdata  = $urandom;
            m_wstrb  = 4'($urandom);
            exp_last = (i == len);
            m_wlast  = exp_last ^ flip[i];
            set_slave(to1, 1'b0, wr_v, 1'b0, 2'b00);
            #1;
            hs = m_wvalid & wr_v;
            chk("w_valid_sel", 64'(to1 ? s1_wvalid : s2_wvalid), 64'(m_wvalid));
            chk("w_valid_other", 64'(to1 ? s2_wvalid : s1_wvalid), 64'(0));
            chk("w_ready", 64'(m_wready), 64'(wr_v));
            chk("s_wlast", 64'(s_wlast), 64'(exp_last));
            chk("wlast_err", 64'(wlast_err), 64'(hs & (m_wlast != exp_last)));
            if (hs) begin
                chk("s_wdata", 64'(s_wdata), 64'(m_wdata));
                chk("s_wstrb", 64'(s_wstrb), 64'(m_wstrb));
                i++;
                if (i == abort_at) begin
                    do_reset();
                    return;
                end
            end
            cyc++;
        end

        done = 0;
        for (int r = 0; r < 200 && !done; r++) begin
            @(negedge clk);
            m_wvalid = 1'($urandom);
            m_wlast  = 1'($urandom);
            m_bready = 1'($urandom);
            bv = (b_dly >= 0) && (r >= b_dly);
            set_slave(to1, 1'b0, 1'b1, bv, bresp);
            #1;
            to  = TMO_EN && (b_dly < 0) && (r >= TMO);
            ebv = to | bv;
            chk("b_valid", 64'(m_bvalid), 64'(ebv));
            if (ebv) chk("b_resp", 64'(m_bresp), 64'(to ? 2'b10 : bresp));
            chk("b_ready_sel", 64'(to1 ? s1_bready : s2_bready), 64'(to ? 1'b0 : m_bready));
            chk("b_ready_other", 64'(to1 ? s2_bready : s1_bready), 64'(0));
            chk("resp_wready", 64'(m_wready), 64'(0));
            chk("resp_wvalid", 64'(s1_wvalid | s2_wvalid | wlast_err), 64'(0));
            if (ebv && m_bready) done = 1;
        end
        if (!done) fail_bound("resp_bound");
        m_wvalid = 0;
    endtask

    initial begin
        int len;
        bit s1;
        do_reset();

        run_txn(1, 0, 32'h10, 32'hDEAD_0000, 3, '0, 0, 0, 0, 0, 2'b00, -1);
        chk("s2_awaddr_untouched", 64'(s2_awaddr), 64'(0));
        run_txn(0, 1, 32'hAAAA_0000, 32'h0, 0, '0, 0, 3, 0, 1, 2'b01, -1);
        run_txn(1, 0, 32'h40, 32'h0, 1, 256'h1, 0, 0, 0, 0, 2'b00, -1);
        run_txn(1, 0, 32'h80, 32'h0, 3, '0, 0, 0, 0, 0, 2'b00, 2);
        run_txn(0, 1, 32'h0, 32'h1234, 3, '0, 0, 0, 0, 0, 2'b11, -1);
        run_txn(1, 1, 32'h55, 32'h66, 2, '0, 30, 0, 2, 3, 2'b10, -1);
        run_txn(0, 1, 32'h0, 32'hFFFF_FFFC, 255, '0, 0, 0, 0, 0, 2'b00, -1);
        run_txn(1, 0, 32'h7000, 32'h0, 255, {1'b1, 254'b0, 1'b1}, 20, 0, 1, 2, 2'b01, -1);
`ifdef WR_ROUTER_TIMEOUT_EN
        run_txn(1, 0, 32'h900, 32'h0, 1, '0, 0, 0, 0, -1, 2'b00, -1);
        @(negedge clk); #1;
        chk("idle_after_timeout", 64'(m_awready), 64'(1));
`endif

        for (int t = 0; t < 30; t++) begin
            len = ($urandom_range(3) == 0) ? int'($urandom_range(255)) : int'($urandom_range(7));
            s1  = 1'($urandom);
            run_txn(s1, ~s1 | 1'($urandom), $urandom, $urandom, len,
                    ($urandom_range(3) == 0) ? {8{$urandom}} : '0,
                    int'($urandom_range(40)), int'($urandom_range(2)), int'($urandom_range(3)),
                    int'($urandom_range(5)), 2'($urandom),
                    ($urandom_range(7) == 0) ? int'($urandom_range(len)) : -1);
        end
        @(negedge clk); #1;
        chk("final_idle", 64'(m_awready), 64'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wr_channel_router.md
# wr_channel_router

Write-channel router for the 1-master/2-slave AXI interconnect, placed directly after the address decoder on the write path. It consumes the decoder's write slave-select and per-slave write-address outputs and captures one write transaction at a time. It then steers the AW, W and B handshakes between the master and the selected slave, counting burst beats to generate WLAST toward the slave. One transaction is in flight at a time; a new AW is not accepted until the B response of the previous one completes.

## Interface
- LEN_W, 8: width of AWLEN; bursts are LEN+1 beats, max 256.
- TIMEOUT_CYCLES, 256: B-response watchdog limit, used only with the timeout feature.
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-high.
- wr_slave1_sel / wr_slave2_sel  in  1 each  decoder select, already qualified by m_awvalid.
- s1_wr_addr / s2_wr_addr  in  32 each  decoder slave-local addresses.
- m_awlen  in  LEN_W  master burst length.
- m_awvalid  in  1,  m_awready  out  1  master AW handshake.
- m_wdata  in  32,  m_wstrb  in  4,  m_wlast  in  1,  m_wvalid  in  1,  m_wready  out  1  master W channel.
- m_bresp  out  2,  m_bvalid  out  1,  m_bready  in  1  master B channel.
- s_awlen  out  LEN_W,  s_wdata  out  32,  s_wstrb  out  4,  s_wlast  out  1  shared to both slaves, qualified by per-slave valids.
- s{1,2}_awaddr  out  32  latched slave-local address.
- s{1,2}_awvalid  out  1,  s{1,2}_awready  in  1  per-slave AW handshake.
- s{1,2}_wvalid  out  1,  s{1,2}_wready  in  1  per-slave W handshake.
- s{1,2}_bresp  in  2,  s{1,2}_bvalid  in  1,  s{1,2}_bready  out  1  per-slave B handshake.
- wlast_err  out  1  one-cycle pulse on a master WLAST mismatch.

## Operation
- FSM states: IDLE, ADDR, DATA, RESP. Reset sets the FSM to IDLE.
- **IDLE**
  - m_awready=1.
  - On m_awvalid & (wr_slave1_sel|wr_slave2_sel): latch sel, address and m_awlen; clear beat_cnt; go to ADDR.
  - If both selects are asserted (illegal), slave 1 wins.
- **ADDR**
  - Selected s*_awvalid=1. On its s*_awready, go to DATA.
- **DATA**
  - Combinational pass-through: s*_wvalid=m_wvalid, m_wready=s*_wready.
  - Each W handshake increments beat_cnt.
  - s_wlast=(beat_cnt==latched len), taken from the counter, never from m_wlast.
  - On the last-beat handshake, go to RESP.
  - wlast_err pulses if m_wlast differs from s_wlast on any handshake beat.
- **RESP**
  - m_bvalid=s*_bvalid, m_bresp=s*_bresp, s*_bready=m_bready.
  - On the handshake, go to IDLE.
- The unselected slave's awvalid, wvalid and bready are held 0 in every state.
- Reset output values: all valids/readies 0, m_bresp=0, s*_awaddr=0, s_awlen=0, wlast_err=0. m_awready rises the cycle after rst deasserts.

## Timing
- AW accepted at edge T; s*_awvalid is high in cycle T+1. Minimum one cycle of added AW latency.
- W and B channels add zero latency (combinational steering). A slave throttling wready throttles the master.
- For a LEN+1 beat burst with no stalls, minimum occupancy is 1 (IDLE) + 1 (ADDR) + LEN+1 (DATA) + 1 (RESP) cycles.
- Back-to-back: after a B handshake at edge N, m_awready=1 in cycle N+1.
- An AWLEN of 0 gives a single beat with s_wlast=1 on the first beat.
- An AWLEN of 255 needs a 9-bit beat_cnt, or a compare before increment; the counter must not wrap early.
- rst asserted in any state:
  - next edge goes to IDLE, beat_cnt=0, all valids 0;
  - the in-flight transaction is abandoned without a B response.
- Master W beats presented while in IDLE or ADDR see m_wready=0.

## Configuration
- WR_ROUTER_TIMEOUT_EN defined:
  - In RESP, a counter runs from 0.
  - If the selected s*_bvalid is not seen within TIMEOUT_CYCLES cycles, the router drives m_bvalid=1, m_bresp=2'b10 (SLVERR) and holds s*_bready=0.
  - After the master handshake it returns to IDLE.
  - The counter clears on leaving RESP.
- Undefined: no counter is built; RESP waits for the slave indefinitely.

## Test plan
- Reset, then idle → all outputs 0 during rst; m_awready=1 on the first cycle after rst falls.
- wr_slave1_sel=1, s1_wr_addr=0x10, awlen=3, both sides always ready → s1_awaddr=0x10, 4 beats on s1, s_wlast on beat 4 only, s1 bresp=OKAY reaches master; slave 2 signals all stay 0.
- wr_slave2_sel=1, s2_wr_addr=0x0, awlen=0, s2_wready low for 3 cycles → m_wready low for those 3 cycles; single beat with s_wlast=1; B routed from s2.
- awlen=1, master asserts m_wlast on beat 1 → wlast_err pulses once; s_wlast still on beat 2; transaction completes normally.
- rst asserted mid-DATA after 2 of 4 beats → next cycle IDLE, no s*_wvalid; following transaction correct from beat 1.
- With WR_ROUTER_TIMEOUT_EN and TIMEOUT_CYCLES=16, s1 never asserts bvalid → m_bvalid with bresp=2'b10 after 16 cycles in RESP; FSM back in IDLE after the handshake.
